alu_seq: RTL and testbench

- Parametrised, registered successor to the combinational CPU ALU.
- Captures operands on a Start handshake and computes:
  - single-cycle logic/arithmetic/shift ops with 1-cycle latency;
  - an iterative shift-add multiply of WIDTH cycles.
- Result and Zero/Overflow/IllegalOp flags are registered and held until the next completion.
- Sits in the EX stage of the multicycle datapath; the control unit waits on Done.

---
 rtl/alu_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered EX-stage ALU: one-cycle logic/arith/shift ops plus an optional
// iterative shift-add multiplier, compiled in when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] InputDataA,
  input  logic [WIDTH-1:0] InputDataB,
  input  logic [WIDTH-1:0] ImmediateDataB,
  input  logic             ALUSrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             IllegalOp
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1011;
`endif

  logic [WIDTH-1:0] opb;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic             ill_c;

  assign opb   = ALUSrcB ? ImmediateDataB : InputDataB;
  assign shamt = opb[SHW-1:0];

  // Single-cycle datapath; MUL is intercepted by the FSM before this is used.
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    ill_c = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        res_c = InputDataA + opb;
        ovf_c = (InputDataA[WIDTH-1] == opb[WIDTH-1]) &&
                (res_c[WIDTH-1] != InputDataA[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = InputDataA - opb;
        ovf_c = (InputDataA[WIDTH-1] != opb[WIDTH-1]) &&
                (res_c[WIDTH-1] != InputDataA[WIDTH-1]);
      end
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(InputDataA) < $signed(opb))};
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (InputDataA < opb)};
      OP_SRL:  res_c = InputDataA >> shamt;
      OP_SLL:  res_c = InputDataA << shamt;
      OP_SRA:  res_c = $unsigned($signed(InputDataA) >>> shamt);
      OP_OR:   res_c = InputDataA | opb;
      OP_AND:  res_c = InputDataA & opb;
      OP_XOR:  res_c = InputDataA ^ opb;
      OP_NOR:  res_c = ~(InputDataA | opb);
      default: ill_c = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = mul_b[count] ? acc + (mul_a << count) : acc;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      IllegalOp <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (ALUOp == OP_MUL) begin
              mul_a <= InputDataA;
              mul_b <= opb;
              acc   <= '0;
              count <= '0;
              Busy  <= 1'b1;
              state <= MUL;
            end else begin
              Result    <= res_c;
              Zero      <= (res_c == '0);
              Overflow  <= ovf_c;
              IllegalOp <= ill_c;
              Done      <= 1'b1;
            end
          end
        end
        MUL: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == SHW'(WIDTH-1)) begin
            Result    <= acc_next;
            Zero      <= (acc_next == '0);
            Overflow  <= 1'b0;
            IllegalOp <= 1'b0;
            Done      <= 1'b1;
            Busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign Busy = 1'b0;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Done      <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      IllegalOp <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Start) begin
        Result    <= res_c;
        Zero      <= (res_c == '0);
        Overflow  <= ovf_c;
        IllegalOp <= ill_c;
        Done      <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); MUL checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic [3:0]  ALUOp;
  logic [31:0] InputDataA;
  logic [31:0] InputDataB;
  logic [31:0] ImmediateDataB;
  logic        ALUSrcB;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        IllegalOp;

  int n_chk = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(32)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .ALUOp(ALUOp),
    .InputDataA(InputDataA), .InputDataB(InputDataB),
    .ImmediateDataB(ImmediateDataB), .ALUSrcB(ALUSrcB),
    .Busy(Busy), .Done(Done), .Result(Result), .Zero(Zero),
    .Overflow(Overflow), .IllegalOp(IllegalOp)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one Start at a negedge, return 1ns after the sampling edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src);
    @(negedge CLK);
    ALUOp = op; InputDataA = a; InputDataB = b; ImmediateDataB = imm; ALUSrcB = src;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] res, input logic z,
                         input logic ov, input logic ill, input logic dn);
    chk({tag, ".res"}, Result, res);
    chk({tag, ".zero"}, {31'b0, Zero}, {31'b0, z});
    chk({tag, ".ovf"}, {31'b0, Overflow}, {31'b0, ov});
    chk({tag, ".ill"}, {31'b0, IllegalOp}, {31'b0, ill});
    chk({tag, ".done"}, {31'b0, Done}, {31'b0, dn});
  endtask

  initial begin
    int n;
    int busy_cnt;
    logic done_seen;

    Reset = 1'b1; Start = 1'b0; ALUOp = 4'h0; InputDataA = '0; InputDataB = '0;
    ImmediateDataB = '0; ALUSrcB = 1'b0;
    #12;
    chk_out("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.busy", {31'b0, Busy}, 32'h0);
    @(negedge CLK); Reset = 1'b0;

    issue(4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0);
    chk_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge CLK); #1;
    chk_out("add_hold", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);

    issue(4'b0001, 32'h5, 32'h9, 32'h5, 1'b1);
    chk_out("sub_imm", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    issue(4'b0001, 32'h8000_0000, 32'h1, 32'h0, 1'b0);
    chk_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);

    issue(4'b0110, 32'h8000_0000, 32'h21, 32'h0, 1'b0);
    chk("sra", Result, 32'hC000_0000);
    issue(4'b0100, 32'h8000_0000, 32'h21, 32'h0, 1'b0);
    chk("srl", Result, 32'h4000_0000);
    issue(4'b0101, 32'h8000_0001, 32'h20, 32'h0, 1'b0);
    chk("sll_amt0", Result, 32'h8000_0001);
    issue(4'b0101, 32'h0000_0003, 32'h4, 32'h0, 1'b0);
    chk("sll", Result, 32'h0000_0030);
    issue(4'b0010, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    chk("slt", Result, 32'h1);
    issue(4'b0011, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    chk_out("sltu", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    issue(4'b1110, 32'h1234, 32'h5678, 32'h0, 1'b0);
    chk_out("illegal", 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("illegal.busy", {31'b0, Busy}, 32'h0);
    issue(4'b1000, 32'hF0, 32'h3C, 32'h0, 1'b0);
    chk_out("and", 32'h30, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back: Start held for three cycles.
    @(negedge CLK);
    InputDataA = 32'hFFFF_0000; InputDataB = 32'h0000_FFFF; ALUSrcB = 1'b0;
    ALUOp = 4'b1001; Start = 1'b1;
    @(posedge CLK); #1;
    chk_out("b2b_xor", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK); ALUOp = 4'b0111;
    @(posedge CLK); #1;
    chk_out("b2b_or", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK); ALUOp = 4'b1010;
    @(posedge CLK); #1;
    chk_out("b2b_nor", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge CLK); Start = 1'b0; ALUOp = 4'b0000; InputDataA = 32'h7; InputDataB = 32'h8;
    @(posedge CLK); #1;
    chk_out("no_start_hold", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SEQ_MUL_EN
    issue(4'b1011, 32'h0001_2345, 32'h100, 32'h0, 1'b0);
    chk("mul.busy0", {31'b0, Busy}, 32'h1);
    chk("mul.done0", {31'b0, Done}, 32'h0);
    busy_cnt = Busy ? 1 : 0;
    n = 0;
    while (n < 100) begin
      ALUOp = 4'b0000; InputDataA = 32'h1; InputDataB = 32'h2;
      Start = (n < 10) && (n % 2 == 0);
      @(posedge CLK); #1;
      n++;
      if (Done) break;
      if (Busy) busy_cnt++;
    end
    Start = 1'b0;
    chk("mul.latency", n, 32);
    chk("mul.busy_cycles", busy_cnt, 32);
    chk_out("mul", 32'h0123_4500, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mul.busy_end", {31'b0, Busy}, 32'h0);

    issue(4'b0000, 32'h1, 32'h2, 32'h0, 1'b0);
    chk_out("after_mul_add", 32'h3, 1'b0, 1'b0, 1'b0, 1'b1);

    issue(4'b1011, 32'h0001_2345, 32'h100, 32'h0, 1'b0);
    repeat (8) @(posedge CLK);
    @(negedge CLK); Reset = 1'b1; #1;
    chk_out("mul_abort", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mul_abort.busy", {31'b0, Busy}, 32'h0);
    @(negedge CLK); Reset = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (Done || Busy) done_seen = 1'b1;
    end
    chk("mul_abort.no_done", {31'b0, done_seen}, 32'h0);
`else
    issue(4'b1011, 32'h0001_2345, 32'h100, 32'h0, 1'b0);
    chk_out("mul_illegal", 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("mul_illegal.busy", {31'b0, Busy}, 32'h0);
    issue(4'b1000, 32'hF0, 32'h3C, 32'h0, 1'b0);
    chk_out("and2", 32'h30, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
